// File: rtl/rgb_sram_writer.sv
// Packs an RGB888 pixel stream into 16-bit SRAM words, three words per pixel pair.
// Define RGB_SRAM_WRITER_ABORT_EN to add an abort input that cancels the frame in progress.
module rgb_sram_writer #(
    parameter int unsigned PIXEL_COUNT = 76800
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic [17:0] SRAM_base_address,
    input  logic        pixel_in_valid,
    input  logic [7:0]  pixel_in_R,
    input  logic [7:0]  pixel_in_G,
    input  logic [7:0]  pixel_in_B,
`ifdef RGB_SRAM_WRITER_ABORT_EN
    input  logic        abort,
`endif
    output logic        pixel_in_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CntW = $clog2(PIXEL_COUNT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(PIXEL_COUNT);

    typedef enum logic [2:0] {StIdle, StEven, StOdd, StFlush, StPad} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [17:0]     next_addr_q, next_addr_d;
    logic [7:0]      hold_g_q, hold_g_d;
    logic [7:0]      hold_b_q, hold_b_d;
    logic [17:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            we_n_q, we_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            done_pend_q, done_pend_d;
    logic            xfer;

    assign pixel_in_ready = (state_q == StEven) || (state_q == StOdd);
    assign xfer           = pixel_in_valid && pixel_in_ready;
    assign cnt_inc        = cnt_q + CntW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        next_addr_d = next_addr_q;
        hold_g_d    = hold_g_q;
        hold_b_d    = hold_b_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        done_pend_d = 1'b0;
        // done trails the cycle in which the last word is on the bus
        done_d      = done_pend_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    next_addr_d = SRAM_base_address;
                    cnt_d       = '0;
                    state_d     = StEven;
                end
            end
            StEven: begin
                if (xfer) begin
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + 18'd1;
                    wdata_d     = {pixel_in_R, pixel_in_G};
                    we_n_d      = 1'b0;
                    hold_b_d    = pixel_in_B;
                    cnt_d       = cnt_inc;
                    state_d     = (cnt_inc == LastCnt) ? StPad : StOdd;
                end
            end
            StOdd: begin
                if (xfer) begin
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + 18'd1;
                    wdata_d     = {hold_b_q, pixel_in_R};
                    we_n_d      = 1'b0;
                    hold_g_d    = pixel_in_G;
                    hold_b_d    = pixel_in_B;
                    cnt_d       = cnt_inc;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                addr_d      = next_addr_q;
                next_addr_d = next_addr_q + 18'd1;
                wdata_d     = {hold_g_q, hold_b_q};
                we_n_d      = 1'b0;
                if (cnt_q == LastCnt) begin
                    state_d     = StIdle;
                    done_pend_d = 1'b1;
                end else begin
                    state_d = StEven;
                end
            end
            StPad: begin
                addr_d      = next_addr_q;
                next_addr_d = next_addr_q + 18'd1;
                wdata_d     = {hold_b_q, 8'h00};
                we_n_d      = 1'b0;
                state_d     = StIdle;
                done_pend_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

`ifdef RGB_SRAM_WRITER_ABORT_EN
        // Abort wins over every transition; the word already on the bus is left to finish.
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            cnt_d       = cnt_q;
            next_addr_d = next_addr_q;
            addr_d      = addr_q;
            wdata_d     = wdata_q;
            we_n_d      = 1'b1;
            hold_g_d    = '0;
            hold_b_d    = '0;
            done_pend_d = 1'b0;
        end
`endif

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            next_addr_q <= '0;
            hold_g_q    <= '0;
            hold_b_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            next_addr_q <= next_addr_d;
            hold_g_q    <= hold_g_d;
            hold_b_q    <= hold_b_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Self-checking bench for rgb_sram_writer: frame-level reference model plus literal scenarios.
// A second instance with PIXEL_COUNT=2 covers the two-pixel literal cases.
module tb_rgb_sram_writer;

    localparam int unsigned P = 3;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic [17:0] base = '0;
    logic        valid = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        abort = 1'b0;
    logic        ready, we_n, busy, done;
    logic [17:0] addr;
    logic [15:0] wdata;

    logic        start2 = 1'b0;
    logic [17:0] base2 = '0;
    logic        valid2 = 1'b0;
    logic [7:0]  r2 = '0, g2 = '0, b2 = '0;
    logic        ready2, we2_n, busy2, done2;
    logic [17:0] addr2;
    logic [15:0] wdata2;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    rgb_sram_writer #(.PIXEL_COUNT(P)) dut (
        .Clock             (Clock),
        .Resetn            (Resetn),
        .start             (start),
        .SRAM_base_address (base),
        .pixel_in_valid    (valid),
        .pixel_in_R        (r),
        .pixel_in_G        (g),
        .pixel_in_B        (b),
`ifdef RGB_SRAM_WRITER_ABORT_EN
        .abort             (abort),
`endif
        .pixel_in_ready    (ready),
        .SRAM_address      (addr),
        .SRAM_write_data   (wdata),
        .SRAM_we_n         (we_n),
        .busy              (busy),
        .done              (done)
    );

    rgb_sram_writer #(.PIXEL_COUNT(2)) dut2 (
        .Clock             (Clock),
        .Resetn            (Resetn),
        .start             (start2),
        .SRAM_base_address (base2),
        .pixel_in_valid    (valid2),
        .pixel_in_R        (r2),
        .pixel_in_G        (g2),
        .pixel_in_B        (b2),
`ifdef RGB_SRAM_WRITER_ABORT_EN
        .abort             (1'b0),
`endif
        .pixel_in_ready    (ready2),
        .SRAM_address      (addr2),
        .SRAM_write_data   (wdata2),
        .SRAM_we_n         (we2_n),
        .busy              (busy2),
        .done              (done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every accepted pixel schedules the words it must produce and when.
    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        int          due;
        bit          last;
    } wr_t;

    wr_t         sched[$];
    int          cyc = 0;
    int          busy_from = 0, busy_until = 0, done_due = -1;
    logic [17:0] last_a = '0;
    logic [15:0] last_d = '0;
    logic [17:0] f_base = '0;
    int          f_pix = 0, f_word = 0;
    logic [7:0]  f_b = '0;
    bit          exp_busy, exp_we, exp_ready;
    wr_t         w;
    logic [17:0] wa;

    bit          obs_en = 1'b0;
    logic [17:0] obs_a[$];
    logic [15:0] obs_d[$];
    int          done_cnt = 0;

    always @(negedge Clock) begin
        cyc++;
        if (!Resetn) begin
            chk("rst_we_n", 32'(we_n), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_addr", 32'(addr), 32'd0);
            chk("rst_data", 32'(wdata), 32'd0);
            sched.delete();
            busy_from = 0; busy_until = 0; done_due = -1;
            last_a = '0; last_d = '0;
        end else begin
            exp_busy  = (cyc >= busy_from) && (cyc < busy_until);
            exp_we    = (sched.size() > 0) && (sched[0].due == cyc);
            exp_ready = exp_busy && !((sched.size() > 0) && (sched[$].due > cyc));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("we_n", 32'(we_n), 32'(!exp_we));
            chk("done", 32'(done), 32'(cyc == done_due));
            if (exp_we) begin
                w = sched.pop_front();
                last_a = w.a;
                last_d = w.d;
                if (w.last) done_due = cyc + 1;
            end
            chk("addr", 32'(addr), 32'(last_a));
            chk("data", 32'(wdata), 32'(last_d));
            if (obs_en && !we_n) begin
                obs_a.push_back(addr);
                obs_d.push_back(wdata);
            end
            if (obs_en && done) done_cnt++;

            if (abort && exp_busy) begin
                sched.delete();
                busy_until = cyc + 1;
            end else if (!exp_busy) begin
                if (start) begin
                    busy_from  = cyc + 1;
                    busy_until = 32'h7fff_ffff;
                    f_base = base;
                    f_pix  = 0;
                    f_word = 0;
                end
            end else if (valid && exp_ready) begin
                wa = f_base + 18'(f_word);
                if (f_pix % 2 == 0) begin
                    sched.push_back('{a: wa, d: {r, g}, due: cyc + 1, last: 1'b0});
                    f_b = b;
                    f_word++;
                    if (f_pix == int'(P) - 1) begin
                        sched.push_back('{a: wa + 18'd1, d: {b, 8'h00}, due: cyc + 2, last: 1'b1});
                        busy_until = cyc + 2;
                        f_word++;
                    end
                end else begin
                    sched.push_back('{a: wa, d: {f_b, r}, due: cyc + 1, last: 1'b0});
                    sched.push_back('{a: wa + 18'd1, d: {g, b}, due: cyc + 2,
                                      last: (f_pix == int'(P) - 1)});
                    if (f_pix == int'(P) - 1) busy_until = cyc + 2;
                    f_word += 2;
                end
                f_pix++;
            end
        end
    end

    // Per-cycle log of the two-pixel instance for literal comparison.
    bit          lg_en = 1'b0;
    int          lg_i = 0;
    logic [6:0]  lg_ready, lg_we_n, lg_busy, lg_done;
    logic [17:0] lg_a[7];
    logic [15:0] lg_d[7];

    always @(negedge Clock) begin
        if (!lg_en) begin
            lg_i = 0;
        end else if (lg_i < 7) begin
            lg_ready[lg_i] = ready2;
            lg_we_n[lg_i]  = we2_n;
            lg_busy[lg_i]  = busy2;
            lg_done[lg_i]  = done2;
            lg_a[lg_i]     = addr2;
            lg_d[lg_i]     = wdata2;
            lg_i++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic run2(input string tag, input logic [17:0] bs, input logic [17:0] e0,
                        input logic [17:0] e1, input logic [17:0] e2);
        logic [6:0]  xr, xw, xb, xd;
        logic [17:0] ea[4];
        logic [15:0] ed[4];
        xr = 7'b000_0110;
        xw = 7'b110_0011;
        xb = 7'b000_1110;
        xd = 7'b010_0000;
        ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e2;
        ed[0] = 16'h1122; ed[1] = 16'h3344; ed[2] = 16'h5566; ed[3] = 16'h5566;
        start2 = 1'b1; base2 = bs; valid2 = 1'b0; lg_en = 1'b1;
        tick();
        base2 = 18'h2AAAA; valid2 = 1'b1; {r2, g2, b2} = {8'h11, 8'h22, 8'h33};
        tick();
        {r2, g2, b2} = {8'h44, 8'h55, 8'h66};
        tick();
        start2 = 1'b0; valid2 = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 7; i++) begin
            chk({tag, "_ready"}, 32'(lg_ready[i]), 32'(xr[i]));
            chk({tag, "_we_n"}, 32'(lg_we_n[i]), 32'(xw[i]));
            chk({tag, "_busy"}, 32'(lg_busy[i]), 32'(xb[i]));
            chk({tag, "_done"}, 32'(lg_done[i]), 32'(xd[i]));
        end
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, 32'(lg_a[i + 2]), 32'(ea[i]));
            chk({tag, "_data"}, 32'(lg_d[i + 2]), 32'(ed[i]));
        end
        lg_en = 1'b0;
        tick();
    endtask

    task automatic send_pix(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
        bit got;
        got = 1'b0;
        valid = 1'b1; r = pr; g = pg; b = pb;
        for (int i = 0; i < 20 && !got; i++) begin
            got = ready;
            tick();
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    initial begin
        logic [17:0] xa[5];
        logic [15:0] xdat[5];
        repeat (2) tick();
        Resetn = 1'b1;
        tick();

        run2("base100", 18'h00100, 18'h00100, 18'h00101, 18'h00102);
        run2("wrap", 18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h00001);

        // Three-pixel frame with a PAD word at the end.
        xa[0] = 18'd0; xa[1] = 18'd1; xa[2] = 18'd2; xa[3] = 18'd3; xa[4] = 18'd4;
        xdat[0] = 16'h0102; xdat[1] = 16'h0304; xdat[2] = 16'h0506;
        xdat[3] = 16'h0708; xdat[4] = 16'h0900;
        obs_a.delete(); obs_d.delete(); done_cnt = 0; obs_en = 1'b1;
        start = 1'b1; base = 18'd0;
        tick();
        start = 1'b0;
        send_pix(8'h01, 8'h02, 8'h03);
        send_pix(8'h04, 8'h05, 8'h06);
        send_pix(8'h07, 8'h08, 8'h09);
        repeat (8) tick();
        chk("p3_nwrites", 32'(obs_a.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_a.size(); i++) begin
            chk("p3_addr", 32'(obs_a[i]), 32'(xa[i]));
            chk("p3_data", 32'(obs_d[i]), 32'(xdat[i]));
        end
        chk("p3_done_cnt", 32'(done_cnt), 32'd1);
        obs_en = 1'b0;
        tick();

        // Asynchronous reset right after the first write of a frame.
        start = 1'b1; base = 18'h1F000;
        tick();
        start = 1'b0;
        send_pix(8'hA1, 8'hB2, 8'hC3);
        chk("pre_rst_we_n", 32'(we_n), 32'd0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("async_rst_we_n", 32'(we_n), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick();
        Resetn = 1'b1;
        valid = 1'b1;
        repeat (5) tick();
        valid = 1'b0;

`ifdef RGB_SRAM_WRITER_ABORT_EN
        obs_a.delete(); obs_d.delete(); done_cnt = 0; obs_en = 1'b1;
        start = 1'b1; base = 18'h00040;
        tick();
        start = 1'b0;
        send_pix(8'h10, 8'h20, 8'h30);
        abort = 1'b1; valid = 1'b1;
        tick();
        abort = 1'b0; valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (6) tick();
        chk("abort_nwrites", 32'(obs_a.size()), 32'd1);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        obs_en = 1'b0;
`endif

        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            base  = 18'($urandom);
            valid = ($urandom_range(0, 3) != 0);
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
`ifdef RGB_SRAM_WRITER_ABORT_EN
            abort = ($urandom_range(0, 63) == 0);
`endif
            tick();
        end
        start = 1'b0; valid = 1'b0; abort = 1'b0;
        repeat (20) tick();
        chk("drain_pending", 32'(sched.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
